// File: rtl/mcp3201_pkg.sv
// Shared types and constants for the MCP3201 emulator.
// The optional LSB-first trailer is selected by MCP3201_EMU_LSB_TRAIL_EN.
package mcp3201_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_NULLB  = 3'd2,
    ST_MSB    = 3'd3,
    ST_LSB    = 3'd4,
    ST_TAIL   = 3'd5
  } state_t;

  localparam int ADC_BITS_DEFAULT = 12;

  // Falling clk_pin edges spent in the sample window and in the null bit.
  localparam int SAMPLE_EDGES = 2;
  localparam int NULL_EDGES   = 1;

endpackage

// File: rtl/mcp3201_emu_if.sv
// Bus interface of the MCP3201 emulator: sample feed, SPI pins and status.
// slave  = the emulator, master = the system / SPI initiator side.
interface mcp3201_emu_if
  import mcp3201_pkg::*;
#(
  parameter int ADC_BITS = ADC_BITS_DEFAULT
) ();

  logic [ADC_BITS-1:0] sample_data;
  logic                sample_valid;
  logic                cs_pin_n;
  logic                clk_pin;
  logic                miso_pin;
  logic                miso_oe;
  logic                busy;
  logic                frame_done;
  logic                frame_abort;
  logic [15:0]         conv_count;

  modport slave (
    input  sample_data, sample_valid, cs_pin_n, clk_pin,
    output miso_pin, miso_oe, busy, frame_done, frame_abort, conv_count
  );

  modport master (
    output sample_data, sample_valid, cs_pin_n, clk_pin,
    input  miso_pin, miso_oe, busy, frame_done, frame_abort, conv_count
  );

endinterface

// File: rtl/mcp3201_emu_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with edge pulses
// derived from the synchronized level.
module pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw pin through the synchronizer and keep the last level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/mcp3201_emu.sv
// MCP3201 SPI ADC emulator: presents the held sample as a conversion frame
// (2 sample clocks, null bit, MSB-first word, optional LSB-first trailer).
// Optional feature macro: MCP3201_EMU_LSB_TRAIL_EN (LSB-first trailer).
module mcp3201_emu
  import mcp3201_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADC_BITS    = ADC_BITS_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  mcp3201_emu_if.slave bus
);

  localparam int                IDX_W       = $clog2(ADC_BITS);
  localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(ADC_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
  localparam logic [1:0]        SAMPLE_LAST = 2'(SAMPLE_EDGES - 1);
  localparam logic [1:0]        NULL_LAST   = 2'(NULL_EDGES - 1);
  localparam int                SET_W       = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0]  SETTLE_MAX  = SET_W'(SYNC_STAGES);

  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_clk_fall, w_clk_rise_unused, w_clk_lvl_unused;
  logic w_start;

  logic [ADC_BITS-1:0] r_hold;
  logic [ADC_BITS-1:0] r_word;
  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [1:0]          r_edge_cnt;
  logic [SET_W-1:0]    r_settle;
  logic                r_armed;
  logic                r_b0_sent;
  logic                r_miso, r_oe, r_busy, r_done, r_abort;
  logic [15:0]         r_count;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (bus.cs_pin_n),
    .o_level (w_cs_lvl),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (bus.clk_pin),
    .o_level (w_clk_lvl_unused),
    .o_rise  (w_clk_rise_unused),
    .o_fall  (w_clk_fall)
  );

  // A frame only starts from a cs fall seen after cs was genuinely high,
  // so the reset value of the synchronizer cannot fake a falling edge.
  assign w_start = w_cs_fall & r_armed & (r_state == ST_IDLE) & ~w_cs_rise;

  // Arm frame start once the synchronizer holds real pin samples showing cs high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else if (r_settle != SETTLE_MAX) begin
      r_settle <= r_settle + SET_W'(1);
    end else if (w_cs_lvl) begin
      r_armed <= 1'b1;
    end
  end

  // Hold register: latest sample offered by the system.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (bus.sample_valid) begin
      r_hold <= bus.sample_data;
    end
  end

  // Frame word capture at frame start; a same-cycle sample bypasses the hold.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_word <= bus.sample_valid ? bus.sample_data : r_hold;
    end
  end

  // Frame sequencer: each state is entered on the falling edge that emits its first bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_edge_cnt <= '0;
      r_b0_sent  <= 1'b0;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (w_cs_rise) begin
        r_abort <= (r_state != ST_IDLE) && !r_b0_sent;
        r_state <= ST_IDLE;
        r_miso  <= 1'b0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_start) begin
        r_state    <= ST_SAMPLE;
        r_edge_cnt <= '0;
        r_b0_sent  <= 1'b0;
        r_miso     <= 1'b0;
        r_oe       <= 1'b1;
        r_busy     <= 1'b1;
      end else if (w_clk_fall) begin
        case (r_state)
          ST_SAMPLE: begin
            r_miso <= 1'b0;
            if (r_edge_cnt == SAMPLE_LAST) begin
              r_state    <= ST_NULLB;
              r_edge_cnt <= '0;
            end else begin
              r_edge_cnt <= r_edge_cnt + 2'd1;
            end
          end
          ST_NULLB: begin
            if (r_edge_cnt == NULL_LAST) begin
              r_state <= ST_MSB;
              r_idx   <= IDX_TOP;
              r_miso  <= r_word[IDX_TOP];
            end else begin
              r_edge_cnt <= r_edge_cnt + 2'd1;
              r_miso     <= 1'b0;
            end
          end
          ST_MSB: begin
            if (r_idx == '0) begin
`ifdef MCP3201_EMU_LSB_TRAIL_EN
              r_state <= ST_LSB;
              r_idx   <= IDX_ONE;
              r_miso  <= r_word[IDX_ONE];
`else
              r_state <= ST_TAIL;
              r_miso  <= 1'b0;
`endif
            end else begin
              r_idx  <= r_idx - IDX_ONE;
              r_miso <= r_word[r_idx - IDX_ONE];
              if (r_idx == IDX_ONE) begin
                r_done    <= 1'b1;
                r_count   <= r_count + 16'd1;
                r_b0_sent <= 1'b1;
              end
            end
          end
`ifdef MCP3201_EMU_LSB_TRAIL_EN
          ST_LSB: begin
            if (r_idx == IDX_TOP) begin
              r_state <= ST_TAIL;
              r_miso  <= 1'b0;
            end else begin
              r_idx  <= r_idx + IDX_ONE;
              r_miso <= r_word[r_idx + IDX_ONE];
            end
          end
`endif
          default: r_miso <= 1'b0;
        endcase
      end
    end
  end

  assign bus.miso_pin    = r_miso;
  assign bus.miso_oe     = r_oe;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_done;
  assign bus.frame_abort = r_abort;
  assign bus.conv_count  = r_count;

endmodule

// File: tb/tb_mcp3201_emu.sv
// Self-checking bench for mcp3201_emu: table of frames plus hand-written
// reset-mid-frame and counter-wrap sequences.
`timescale 1ns/1ps
module tb_mcp3201_emu;
  import mcp3201_pkg::*;

  localparam int SYNC = 2;
  localparam int AB   = 12;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcp3201_emu_if #(.ADC_BITS(AB)) bus ();

  mcp3201_emu #(.SYNC_STAGES(SYNC), .ADC_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] hold;
    logic        coll;
    logic [11:0] coll_data;
    int          n_edges;
    int          exp_done;
    int          exp_abort;
  } vec_t;

  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_done  = 0;
  int   n_abort = 0;
  logic exp_q[$];
  vec_t vecs[7];

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1)  n_done++;
    if (bus.frame_abort === 1'b1) n_abort++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected miso after falling edge e of a frame carrying word w.
  function automatic logic exp_bit(input logic [11:0] w, input int e);
    if (e >= 3 && e <= 14) return w[14 - e];
`ifdef MCP3201_EMU_LSB_TRAIL_EN
    if (e >= 15 && e <= 25) return w[e - 14];
`endif
    return 1'b0;
  endfunction

  task automatic load_hold(input logic [11:0] v);
    bus.sample_data  = v;
    bus.sample_valid = 1'b1;
    tick(1);
    bus.sample_valid = 1'b0;
    tick(2);
  endtask

  task automatic spi_falls(input int n, input logic [11:0] w, input bit chk);
    logic e;
    for (int k = 1; k <= n; k++) begin
      bus.clk_pin = 1'b1;
      tick(HALF);
      bus.clk_pin = 1'b0;
      if (chk) exp_q.push_back(exp_bit(w, k));
      tick(HALF);
      if (chk) begin
        e = exp_q.pop_front();
        check($sformatf("miso_e%0d", k), 32'(bus.miso_pin), 32'(e));
      end
    end
  endtask

  task automatic run_frame(input vec_t v);
    int          d0, a0;
    logic [15:0] c0;
    logic [11:0] w;
    load_hold(v.hold);
    d0 = n_done;
    a0 = n_abort;
    c0 = bus.conv_count;
    w  = v.coll ? v.coll_data : v.hold;
    bus.cs_pin_n = 1'b0;
    if (v.coll) begin
      repeat (SYNC) @(negedge clk);
      bus.sample_data  = v.coll_data;
      bus.sample_valid = 1'b1;
      tick(1);
      bus.sample_valid = 1'b0;
      tick(3);
    end else begin
      tick(SYNC + 4);
    end
    check("oe_in_frame", 32'(bus.miso_oe), 32'd1);
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    spi_falls(v.n_edges, w, 1'b1);
    bus.cs_pin_n = 1'b1;
    tick(SYNC + 2);
    check("oe_after_cs", 32'(bus.miso_oe), 32'd0);
    check("busy_after_cs", 32'(bus.busy), 32'd0);
    check("miso_after_cs", 32'(bus.miso_pin), 32'd0);
    tick(4);
    check("done_pulses", 32'(n_done - d0), 32'(v.exp_done));
    check("abort_pulses", 32'(n_abort - a0), 32'(v.exp_abort));
    check("conv_count", 32'(bus.conv_count), 32'(16'(c0 + 16'(v.exp_done))));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 32'(bus.miso_pin), 32'd0);
    check({tag, "_oe"}, 32'(bus.miso_oe), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.frame_done), 32'd0);
    check({tag, "_abort"}, 32'(bus.frame_abort), 32'd0);
    check({tag, "_count"}, 32'(bus.conv_count), 32'd0);
  endtask

  initial begin
    int a0, d0;
    vecs[0] = '{hold: 12'hABC, coll: 1'b0, coll_data: 12'h000, n_edges: 16, exp_done: 1, exp_abort: 0};
    vecs[1] = '{hold: 12'hFFF, coll: 1'b0, coll_data: 12'h000, n_edges: 8,  exp_done: 0, exp_abort: 1};
    vecs[2] = '{hold: 12'h555, coll: 1'b1, coll_data: 12'h123, n_edges: 16, exp_done: 1, exp_abort: 0};
    vecs[3] = '{hold: 12'h801, coll: 1'b0, coll_data: 12'h000, n_edges: 26, exp_done: 1, exp_abort: 0};
    vecs[4] = '{hold: 12'h3A5, coll: 1'b0, coll_data: 12'h000, n_edges: 14, exp_done: 1, exp_abort: 0};
    vecs[5] = '{hold: 12'h5A3, coll: 1'b0, coll_data: 12'h000, n_edges: 13, exp_done: 0, exp_abort: 1};
    vecs[6] = '{hold: 12'h7E1, coll: 1'b0, coll_data: 12'h000, n_edges: 0,  exp_done: 0, exp_abort: 1};

    rst              = 1'b1;
    bus.cs_pin_n     = 1'b1;
    bus.clk_pin      = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(6);

    // Basic frame first so the absolute count is known.
    run_frame(vecs[0]);
    check("count_first_frame", 32'(bus.conv_count), 32'd1);

    for (int i = 1; i < 7; i++) run_frame(vecs[i]);

    // Clock edges with cs high must not start anything.
    d0 = n_done;
    spi_falls(6, 12'h000, 1'b0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_oe", 32'(bus.miso_oe), 32'd0);
    check("idle_done", 32'(n_done - d0), 32'd0);

    // Reset in the middle of a frame while cs stays low.
    load_hold(12'h3C5);
    bus.cs_pin_n = 1'b0;
    tick(SYNC + 4);
    spi_falls(6, 12'h3C5, 1'b0);
    a0 = n_abort;
    d0 = n_done;
    rst = 1'b1;
    tick(2);
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick(4);
    spi_falls(20, 12'h000, 1'b1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_oe", 32'(bus.miso_oe), 32'd0);
    check("midrst_no_abort", 32'(n_abort - a0), 32'd0);
    check("midrst_no_done", 32'(n_done - d0), 32'd0);
    bus.cs_pin_n = 1'b1;
    tick(HALF);
    run_frame(vecs[0]);
    check("midrst_count", 32'(bus.conv_count), 32'd1);

    // Counter wrap: preset to 0xFFFF, then one more completed frame.
    force dut.r_count = 16'hFFFF;
    tick(1);
    release dut.r_count;
    tick(1);
    run_frame(vecs[3]);
    check("count_wrap", 32'(bus.conv_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
